// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: DEC-stage hazard/bypass bundle between the pipeline
// (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int NUM_SRC = 2,
    parameter int XLEN    = 32,
    parameter int PERF_W  = 32
);
    logic [5*NUM_SRC-1:0]    dec_rs;
    logic [NUM_SRC-1:0]      dec_rs_renb;
    logic [XLEN*NUM_SRC-1:0] dec_rdata;
    logic [4:0]              dec_rd;
    logic                    dec_rd_wenb;
    logic                    dec_long;

    logic [4:0]              exe_rd;
    logic                    exe_rd_wenb;
    logic [XLEN-1:0]         exe_result;
    logic                    exe_load;
    logic                    exe_csr;

    logic [4:0]              mem_rd;
    logic                    mem_rd_wenb;
    logic [XLEN-1:0]         mem_result;

    logic [4:0]              wrb_rd;
    logic                    wrb_rd_wenb;
    logic [XLEN-1:0]         wrb_result;

    logic                    lng_issue;
    logic [4:0]              lng_rd;
    logic                    lng_done;
    logic [4:0]              lng_done_rd;
    logic [XLEN-1:0]         lng_done_data;

    logic                    dec_stall;
    logic                    dec_load_use;
    logic                    dec_csr_use;
    logic                    dec_sb_use;
    logic [XLEN*NUM_SRC-1:0] dec_rs_data;
    logic                    sb_full;
    logic [PERF_W-1:0]       perf_stall_cnt;
    logic [PERF_W-1:0]       perf_sb_cnt;

    modport master (
        output dec_rs, dec_rs_renb, dec_rdata, dec_rd, dec_rd_wenb, dec_long,
        output exe_rd, exe_rd_wenb, exe_result, exe_load, exe_csr,
        output mem_rd, mem_rd_wenb, mem_result,
        output wrb_rd, wrb_rd_wenb, wrb_result,
        output lng_issue, lng_rd, lng_done, lng_done_rd, lng_done_data,
        input  dec_stall, dec_load_use, dec_csr_use, dec_sb_use, dec_rs_data,
        input  sb_full, perf_stall_cnt, perf_sb_cnt
    );

    modport slave (
        input  dec_rs, dec_rs_renb, dec_rdata, dec_rd, dec_rd_wenb, dec_long,
        input  exe_rd, exe_rd_wenb, exe_result, exe_load, exe_csr,
        input  mem_rd, mem_rd_wenb, mem_result,
        input  wrb_rd, wrb_rd_wenb, wrb_result,
        input  lng_issue, lng_rd, lng_done, lng_done_rd, lng_done_data,
        output dec_stall, dec_load_use, dec_csr_use, dec_sb_use, dec_rs_data,
        output sb_full, perf_stall_cnt, perf_sb_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: DEC-stage bypass/stall unit with a register scoreboard for
// long-latency ops that write back out of order.
// Optional feature: define HAZARD_PERF_EN to build the saturating stall
// performance counters; otherwise both counter outputs are tied to zero.
module hazard_scoreboard #(
    parameter int NUM_SRC   = 2,
    parameter int XLEN      = 32,
    parameter int MAX_OUTST = 4,
    parameter int PERF_W    = 32
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave bus
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] C_MAX = OW'(MAX_OUTST);

    // Scoreboard state: one pending bit per architectural register (x0 excluded).
    logic [31:1]        r_pending;
    logic [OW-1:0]      r_outst;

    logic [31:0]        w_pend_vec;
    logic [31:1]        w_pend_nxt;
    logic [NUM_SRC-1:0] w_raw;
    logic [NUM_SRC-1:0] w_load_hit;
    logic [NUM_SRC-1:0] w_csr_hit;
    logic               w_waw;
    logic               w_full;
    logic               w_full_stall;
    logic               w_sb_use;
    logic               w_stall;
    logic               w_issue_ok;
    logic               w_done_ok;

    // x0 reads as never pending so operand lookups need no special case.
    assign w_pend_vec = {r_pending, 1'b0};
    assign w_full     = (r_outst == C_MAX);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [4:0]      w_rs;
        logic            w_rd_en;
        logic            w_exe_hit;
        logic            w_mem_hit;
        logic            w_wrb_hit;
        logic            w_lng_hit;
        logic [XLEN-1:0] w_fwd;

        assign w_rs      = bus.dec_rs[5*g +: 5];
        assign w_rd_en   = bus.dec_rs_renb[g] && (w_rs != 5'd0);
        assign w_exe_hit = w_rd_en && bus.exe_rd_wenb && (bus.exe_rd == w_rs);
        assign w_mem_hit = w_rd_en && bus.mem_rd_wenb && (bus.mem_rd == w_rs);
        assign w_wrb_hit = w_rd_en && bus.wrb_rd_wenb && (bus.wrb_rd == w_rs);
        assign w_lng_hit = w_rd_en && bus.lng_done && (bus.lng_done_rd == w_rs);

        assign w_load_hit[g] = w_exe_hit && bus.exe_load;
        assign w_csr_hit[g]  = w_exe_hit && bus.exe_csr;
        assign w_raw[g]      = w_rd_en && w_pend_vec[w_rs] && !w_lng_hit
                               && !w_exe_hit && !w_mem_hit && !w_wrb_hit;

        // Take the youngest in-flight producer of this operand, else the register file.
        always_comb begin
            if (w_exe_hit)      w_fwd = bus.exe_result;
            else if (w_mem_hit) w_fwd = bus.mem_result;
            else if (w_wrb_hit) w_fwd = bus.wrb_result;
            else if (w_lng_hit) w_fwd = bus.lng_done_data;
            else                w_fwd = bus.dec_rdata[XLEN*g +: XLEN];
        end

        assign bus.dec_rs_data[XLEN*g +: XLEN] = w_fwd;
    end

    // A write to a register still owned by a long op must wait unless it lands now.
    assign w_waw = bus.dec_rd_wenb && (bus.dec_rd != 5'd0) && w_pend_vec[bus.dec_rd]
                   && !(bus.lng_done && (bus.lng_done_rd == bus.dec_rd));
    assign w_full_stall = bus.dec_long && w_full && !bus.lng_done;

    assign w_sb_use         = (|w_raw) || w_waw || w_full_stall;
    assign w_stall          = (|w_load_hit) || (|w_csr_hit) || w_sb_use;
    assign bus.dec_load_use = |w_load_hit;
    assign bus.dec_csr_use  = |w_csr_hit;
    assign bus.dec_sb_use   = w_sb_use;
    assign bus.dec_stall    = w_stall;
    assign bus.sb_full      = w_full;

    // Issues while full and completions of non-pending registers are dropped.
    assign w_issue_ok = bus.lng_issue && (bus.lng_rd != 5'd0) && !w_full;
    assign w_done_ok  = bus.lng_done && (bus.lng_done_rd != 5'd0) && w_pend_vec[bus.lng_done_rd];

    // Next pending vector: clear the completing register first so a same-cycle issue wins.
    always_comb begin
        w_pend_nxt = r_pending;
        for (int r = 1; r < 32; r++) begin
            if (w_done_ok && (bus.lng_done_rd == 5'(r))) w_pend_nxt[r] = 1'b0;
            if (w_issue_ok && (bus.lng_rd == 5'(r)))     w_pend_nxt[r] = 1'b1;
        end
    end

    // Scoreboard registers; outstanding count moves only when exactly one of issue/done is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_outst   <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            if (w_issue_ok && !w_done_ok)      r_outst <= r_outst + OW'(1);
            else if (!w_issue_ok && w_done_ok) r_outst <= r_outst - OW'(1);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_sb_cnt;

    // Saturating stall counters sampled at each clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_sb_cnt    <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {PERF_W{1'b1}})) r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            if (w_sb_use && (r_sb_cnt != {PERF_W{1'b1}}))   r_sb_cnt    <= r_sb_cnt + PERF_W'(1);
        end
    end

    assign bus.perf_stall_cnt = r_stall_cnt;
    assign bus.perf_sb_cnt    = r_sb_cnt;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_sb_cnt    = '0;
`endif

    // Issuing into a full scoreboard is a pipeline protocol violation.
    a_no_issue_when_full: assert property (@(posedge clk) disable iff (reset)
        !(bus.lng_issue && (bus.lng_rd != 5'd0) && w_full));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table vectors, directed multi-cycle sequences and a
// randomized run checked against a behavioural scoreboard model.
module tb_hazard_scoreboard;
    localparam int NS   = 2;
    localparam int XW   = 32;
    localparam int MAXO = 4;
    localparam int PW   = 4;
    localparam longint PMAX = (longint'(1) << PW) - 1;

    typedef struct {
        int unsigned rs0, rs1, renb;
        int unsigned exeRd, exeWenb, exeLoad, exeCsr;
        int unsigned memRd, memWenb, wrbRd, wrbWenb;
        int unsigned lngDone, lngDoneRd;
        int unsigned expD0, expD1, expLoad, expCsr, expStall;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_SRC(NS), .XLEN(XW), .PERF_W(PW)) bus ();

    hazard_scoreboard #(.NUM_SRC(NS), .XLEN(XW), .MAX_OUTST(MAXO), .PERF_W(PW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Reference model state
    logic [31:0]        mPend;
    int                 mOutst;
    longint             mStall, mSb;
    logic [NS*XW-1:0]   expData;
    logic               expLoad, expCsr, expSb, expStall;
    int                 nChecks = 0;
    int                 nPass   = 0;
    vec_t               tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Value seen by an operand = first producer in age order that targets it.
    function automatic void modelComb();
        logic [4:0]    srcRd [4];
        logic          srcOn [4];
        logic [XW-1:0] srcVal[4];
        logic [4:0]    rs;
        logic          reads, raw, waw, full;
        int            found;
        srcOn[0] = bus.exe_rd_wenb; srcRd[0] = bus.exe_rd;      srcVal[0] = bus.exe_result;
        srcOn[1] = bus.mem_rd_wenb; srcRd[1] = bus.mem_rd;      srcVal[1] = bus.mem_result;
        srcOn[2] = bus.wrb_rd_wenb; srcRd[2] = bus.wrb_rd;      srcVal[2] = bus.wrb_result;
        srcOn[3] = bus.lng_done;    srcRd[3] = bus.lng_done_rd; srcVal[3] = bus.lng_done_data;
        expData = bus.dec_rdata;
        expLoad = 1'b0;
        expCsr  = 1'b0;
        raw     = 1'b0;
        for (int i = 0; i < NS; i++) begin
            rs    = bus.dec_rs[5*i +: 5];
            reads = bus.dec_rs_renb[i] && (rs != 5'd0);
            found = -1;
            if (reads)
                for (int s = 0; s < 4; s++)
                    if (found < 0 && srcOn[s] && srcRd[s] == rs) found = s;
            if (found >= 0) expData[i*XW +: XW] = srcVal[found];
            if (found == 0 && bus.exe_load) expLoad = 1'b1;
            if (found == 0 && bus.exe_csr)  expCsr  = 1'b1;
            if (reads && mPend[rs] && found < 0) raw = 1'b1;
        end
        waw = bus.dec_rd_wenb && (bus.dec_rd != 5'd0) && mPend[bus.dec_rd]
              && !(bus.lng_done && bus.lng_done_rd == bus.dec_rd);
        full = bus.dec_long && (mOutst == MAXO) && !bus.lng_done;
        expSb    = raw || waw || full;
        expStall = expSb || expLoad || expCsr;
    endfunction

    function automatic void modelAdvance();
        logic issueOk, doneOk;
        modelComb();
        if (expStall && mStall < PMAX) mStall++;
        if (expSb && mSb < PMAX) mSb++;
        issueOk = bus.lng_issue && bus.lng_rd != 5'd0 && mOutst < MAXO;
        doneOk  = bus.lng_done && bus.lng_done_rd != 5'd0 && mPend[bus.lng_done_rd];
        if (doneOk)  mPend[bus.lng_done_rd] = 1'b0;
        if (issueOk) mPend[bus.lng_rd] = 1'b1;
        mOutst = mOutst + (issueOk ? 1 : 0) - (doneOk ? 1 : 0);
    endfunction

    function automatic void modelReset();
        mPend = '0; mOutst = 0; mStall = 0; mSb = 0;
    endfunction

    task automatic tick();
        if (!reset) modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        modelComb();
        check({tag, ".stall"},    64'(bus.dec_stall),    64'(expStall));
        check({tag, ".load_use"}, 64'(bus.dec_load_use), 64'(expLoad));
        check({tag, ".csr_use"},  64'(bus.dec_csr_use),  64'(expCsr));
        check({tag, ".sb_use"},   64'(bus.dec_sb_use),   64'(expSb));
        for (int i = 0; i < NS; i++)
            check($sformatf("%s.data%0d", tag, i), 64'(bus.dec_rs_data[i*XW +: XW]), 64'(expData[i*XW +: XW]));
        check({tag, ".sb_full"}, 64'(bus.sb_full), 64'(mOutst == MAXO));
`ifdef HAZARD_PERF_EN
        check({tag, ".perf_stall"}, 64'(bus.perf_stall_cnt), 64'(mStall));
        check({tag, ".perf_sb"},    64'(bus.perf_sb_cnt),    64'(mSb));
`else
        check({tag, ".perf_stall"}, 64'(bus.perf_stall_cnt), 64'(0));
        check({tag, ".perf_sb"},    64'(bus.perf_sb_cnt),    64'(0));
`endif
    endtask

    task automatic setIdle();
        bus.dec_rs = '0; bus.dec_rs_renb = '0; bus.dec_rd = '0; bus.dec_rd_wenb = 1'b0; bus.dec_long = 1'b0;
        bus.exe_rd = '0; bus.exe_rd_wenb = 1'b0; bus.exe_load = 1'b0; bus.exe_csr = 1'b0;
        bus.mem_rd = '0; bus.mem_rd_wenb = 1'b0; bus.wrb_rd = '0; bus.wrb_rd_wenb = 1'b0;
        bus.lng_issue = 1'b0; bus.lng_rd = '0; bus.lng_done = 1'b0; bus.lng_done_rd = '0;
        bus.exe_result = 32'h11; bus.mem_result = 32'h22; bus.wrb_result = 32'h33;
        bus.lng_done_data = 32'h44; bus.dec_rdata = {32'hB1, 32'hA0};
    endtask

    task automatic applyStimulus(input vec_t v);
        setIdle();
        bus.dec_rs      = {5'(v.rs1), 5'(v.rs0)};
        bus.dec_rs_renb = 2'(v.renb);
        bus.exe_rd = 5'(v.exeRd); bus.exe_rd_wenb = 1'(v.exeWenb);
        bus.exe_load = 1'(v.exeLoad); bus.exe_csr = 1'(v.exeCsr);
        bus.mem_rd = 5'(v.memRd); bus.mem_rd_wenb = 1'(v.memWenb);
        bus.wrb_rd = 5'(v.wrbRd); bus.wrb_rd_wenb = 1'(v.wrbWenb);
        bus.lng_done = 1'(v.lngDone); bus.lng_done_rd = 5'(v.lngDoneRd);
    endtask

    task automatic issueLong(input logic [4:0] rd, input string tag);
        setIdle();
        bus.lng_issue = 1'b1; bus.lng_rd = rd;
        #1; checkOutput(tag); tick();
    endtask

    task automatic doneLong(input logic [4:0] rd, input string tag);
        setIdle();
        bus.lng_done = 1'b1; bus.lng_done_rd = rd;
        #1; checkOutput(tag); tick();
    endtask

    initial begin
        logic [4:0] r;
        int q[$];

        // rs0 rs1 renb | exe rd/w/ld/csr | mem rd/w | wrb rd/w | lng d/rd | d0 d1 load csr stall
        tbl[0]  = '{5, 0, 1,  5, 1, 0, 0,  5, 1,  0, 0,  0, 0,  'h11, 'hB1, 0, 0, 0};
        tbl[1]  = '{5, 0, 1,  0, 0, 0, 0,  5, 1,  0, 0,  0, 0,  'h22, 'hB1, 0, 0, 0};
        tbl[2]  = '{5, 6, 3,  0, 0, 0, 0,  6, 1,  5, 1,  0, 0,  'h33, 'h22, 0, 0, 0};
        tbl[3]  = '{5, 0, 1,  0, 0, 0, 0,  0, 0,  5, 1,  1, 5,  'h33, 'hB1, 0, 0, 0};
        tbl[4]  = '{5, 5, 3,  0, 0, 0, 0,  0, 0,  0, 0,  1, 5,  'h44, 'h44, 0, 0, 0};
        tbl[5]  = '{0, 7, 2,  7, 1, 1, 0,  0, 0,  0, 0,  0, 0,  'hA0, 'h11, 1, 0, 1};
        tbl[6]  = '{0, 7, 0,  7, 1, 1, 0,  0, 0,  0, 0,  0, 0,  'hA0, 'hB1, 0, 0, 0};
        tbl[7]  = '{8, 0, 1,  8, 1, 0, 1,  0, 0,  0, 0,  0, 0,  'h11, 'hB1, 0, 1, 1};
        tbl[8]  = '{0, 0, 3,  0, 1, 1, 1,  0, 1,  0, 1,  1, 0,  'hA0, 'hB1, 0, 0, 0};
        tbl[9]  = '{5, 0, 1,  5, 0, 1, 1,  0, 0,  0, 0,  0, 0,  'hA0, 'hB1, 0, 0, 0};
        tbl[10] = '{4, 4, 3,  4, 1, 1, 1,  0, 0,  0, 0,  0, 0,  'h11, 'h11, 1, 1, 1};
        tbl[11] = '{5, 0, 1,  5, 1, 1, 0,  5, 1,  0, 0,  0, 0,  'h11, 'hB1, 1, 0, 1};
        tbl[12] = '{3, 0, 1,  9, 1, 1, 0,  3, 1,  0, 0,  0, 0,  'h22, 'hB1, 0, 0, 0};

        reset = 1'b1;
        setIdle();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        reset = 1'b0;

        $display("[TB] table vectors");
        for (int k = 0; k < 13; k++) begin
            applyStimulus(tbl[k]);
            #1;
            check($sformatf("tbl%0d.data0", k), 64'(bus.dec_rs_data[XW-1:0]),    64'(tbl[k].expD0));
            check($sformatf("tbl%0d.data1", k), 64'(bus.dec_rs_data[2*XW-1:XW]), 64'(tbl[k].expD1));
            check($sformatf("tbl%0d.load", k),  64'(bus.dec_load_use),           64'(tbl[k].expLoad));
            check($sformatf("tbl%0d.csr", k),   64'(bus.dec_csr_use),            64'(tbl[k].expCsr));
            check($sformatf("tbl%0d.stall", k), 64'(bus.dec_stall),              64'(tbl[k].expStall));
            checkOutput($sformatf("tbl%0d", k));
            tick();
        end

        $display("[TB] long-op RAW with same-cycle completion");
        issueLong(5'd9, "s3.issue");
        setIdle(); bus.dec_rs = {5'd0, 5'd9}; bus.dec_rs_renb = 2'b01;
        #1; check("s3.raw_stall", 64'(bus.dec_stall), 64'(1)); check("s3.raw_sb", 64'(bus.dec_sb_use), 64'(1));
        checkOutput("s3.raw"); tick();
        setIdle(); bus.dec_rs = {5'd0, 5'd9}; bus.dec_rs_renb = 2'b01;
        bus.lng_done = 1'b1; bus.lng_done_rd = 5'd9; bus.lng_done_data = 32'hABCD;
        #1; check("s3.done_stall", 64'(bus.dec_stall), 64'(0));
        check("s3.done_data", 64'(bus.dec_rs_data[XW-1:0]), 64'(32'hABCD));
        checkOutput("s3.done"); tick();
        setIdle(); bus.dec_rs = {5'd0, 5'd9}; bus.dec_rs_renb = 2'b01;
        #1; check("s3.after_stall", 64'(bus.dec_stall), 64'(0)); checkOutput("s3.after"); tick();

        $display("[TB] scoreboard full");
        for (int k = 1; k <= 4; k++) issueLong(5'(k), $sformatf("s4.issue%0d", k));
        setIdle(); #1; check("s4.full", 64'(bus.sb_full), 64'(1));
        bus.dec_long = 1'b1;
        #1; check("s4.long_stall", 64'(bus.dec_stall), 64'(1)); checkOutput("s4.long"); tick();
        setIdle(); bus.dec_long = 1'b1; bus.lng_done = 1'b1; bus.lng_done_rd = 5'd2;
        #1; check("s4.long_done_stall", 64'(bus.dec_stall), 64'(0)); checkOutput("s4.long_done"); tick();
        setIdle(); #1; check("s4.not_full", 64'(bus.sb_full), 64'(0));
        doneLong(5'd2, "s4.done_nonpending");
        issueLong(5'd2, "s4.refill");
        setIdle(); #1; check("s4.full_again", 64'(bus.sb_full), 64'(1));
        doneLong(5'd3, "s4.done3");
        setIdle(); bus.lng_issue = 1'b1; bus.lng_rd = 5'd4; bus.lng_done = 1'b1; bus.lng_done_rd = 5'd4;
        #1; checkOutput("s4.same_rd"); tick();
        setIdle(); bus.dec_rs = {5'd0, 5'd4}; bus.dec_rs_renb = 2'b01;
        #1; check("s4.set_wins", 64'(bus.dec_sb_use), 64'(1));
        check("s4.three_outst", 64'(bus.sb_full), 64'(0)); checkOutput("s4.set_wins"); tick();
        doneLong(5'd1, "s4.clr1"); doneLong(5'd2, "s4.clr2"); doneLong(5'd4, "s4.clr4");

        $display("[TB] WAW");
        issueLong(5'd3, "s5.issue");
        setIdle(); bus.dec_rd = 5'd3; bus.dec_rd_wenb = 1'b1;
        #1; check("s5.waw_stall", 64'(bus.dec_stall), 64'(1)); checkOutput("s5.waw"); tick();
        setIdle(); bus.dec_rd = 5'd3; bus.dec_rd_wenb = 1'b1; bus.lng_done = 1'b1; bus.lng_done_rd = 5'd3;
        #1; check("s5.waw_done", 64'(bus.dec_stall), 64'(0)); checkOutput("s5.waw_done"); tick();
        setIdle(); bus.dec_rd = 5'd3; bus.dec_rd_wenb = 1'b1;
        #1; check("s5.waw_clear", 64'(bus.dec_stall), 64'(0)); checkOutput("s5.waw_clear"); tick();

        $display("[TB] reset mid-operation");
        for (int k = 10; k <= 12; k++) issueLong(5'(k), $sformatf("s6.issue%0d", k));
        reset = 1'b1;
        modelReset();
        setIdle(); bus.dec_rs = {5'd11, 5'd10}; bus.dec_rs_renb = 2'b11;
        #1;
        check("s6.stall", 64'(bus.dec_stall), 64'(0));
        check("s6.full", 64'(bus.sb_full), 64'(0));
        check("s6.perf_stall", 64'(bus.perf_stall_cnt), 64'(0));
        check("s6.perf_sb", 64'(bus.perf_sb_cnt), 64'(0));
        tick();
        reset = 1'b0;
        doneLong(5'd10, "s6.stale_done");
        for (int k = 1; k <= 4; k++) issueLong(5'(k), $sformatf("s6.refill%0d", k));
        for (int k = 1; k <= 4; k++) doneLong(5'(k), $sformatf("s6.drain%0d", k));

        $display("[TB] randomized run");
        for (int n = 0; n < 400; n++) begin
            setIdle();
            bus.dec_rs      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.dec_rs_renb = 2'($urandom);
            bus.dec_rdata   = {$urandom, $urandom};
            bus.dec_rd      = 5'($urandom_range(0, 7));
            bus.dec_rd_wenb = 1'($urandom);
            bus.dec_long    = ($urandom_range(0, 3) == 0);
            bus.exe_rd = 5'($urandom_range(0, 7)); bus.exe_rd_wenb = 1'($urandom); bus.exe_result = $urandom;
            bus.exe_load = ($urandom_range(0, 3) == 0); bus.exe_csr = ($urandom_range(0, 3) == 0);
            bus.mem_rd = 5'($urandom_range(0, 7)); bus.mem_rd_wenb = 1'($urandom); bus.mem_result = $urandom;
            bus.wrb_rd = 5'($urandom_range(0, 7)); bus.wrb_rd_wenb = 1'($urandom); bus.wrb_result = $urandom;
            q.delete();
            for (int k = 1; k < 8; k++) if (mPend[k]) q.push_back(k);
            bus.lng_done = ($urandom_range(0, 2) == 0);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                bus.lng_done_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                bus.lng_done_rd = 5'($urandom_range(0, 7));
            bus.lng_done_data = $urandom;
            r = 5'($urandom_range(0, 7));
            bus.lng_rd = r;
            bus.lng_issue = ($urandom_range(0, 2) == 0) &&
                            ((r == 5'd0) || (mOutst < MAXO &&
                             (!mPend[r] || (bus.lng_done && bus.lng_done_rd == r))));
            #1;
            checkOutput($sformatf("rnd%0d", n));
            tick();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
